// File: rtl/clk_trig_monitor.sv
// clk_trig_monitor: receive-side checker for a divided clock and its trigger
// Optional duty-cycle check is built when DUTY_CHECK_EN is defined.
// Ports:
//   fastclk, reset        system clock, synchronous active-high reset
//   clk_in, trig_in       monitored clock and trigger, asynchronous to fastclk
//   period_out, high_out  last measured period and high time, in fastclk cycles
//   meas_valid            one-cycle pulse when period_out/high_out update
//   sel_code, sel_valid   decoded divider selection and its match flag
//   locked                LOCK_CNT consecutive matches of the same selection
//   clk_lost              sticky timeout flag, cleared by the next measurement
//   trig_pulse            one-cycle pulse per synchronised trigger rising edge
//   trig_count            wrapping count of trigger rising edges
//   trig_phase            phase counter value captured at the trigger edge
//   duty_err              duty-cycle error flag (tied 0 without DUTY_CHECK_EN)
module clk_trig_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int P0          = 4,
    parameter int P1          = 8,
    parameter int P2          = 16,
    parameter int P3          = 32,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             trig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic [1:0]       sel_code,
    output logic             sel_valid,
    output logic             locked,
    output logic             clk_lost,
    output logic             trig_pulse,
    output logic [7:0]       trig_count,
    output logic [CNT_W-1:0] trig_phase,
    output logic             duty_err
);
    typedef enum logic {IDLE, MEAS} state_t;
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ONES = '1;
    localparam int               MW   = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    LCK  = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    M1   = MW'(1);

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] clk_sync, trig_sync;
    logic                   clk_d, trig_d, clk_s, clk_rise, trig_rise;
    logic                   meas, tout, hit;
    logic [1:0]             dec;
    logic [CNT_W-1:0]       phase, high;
    logic [MW-1:0]          mcnt;

    function automatic logic near(input logic [CNT_W-1:0] p, input int px);
        logic [CNT_W+1:0] a;
        a = {2'b00, p};
        return (a + (CNT_W+2)'(TOL) >= (CNT_W+2)'(px)) && (a <= (CNT_W+2)'(px + TOL));
    endfunction

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_d;
    assign trig_rise = trig_sync[SYNC_STAGES-1] & ~trig_d;
    assign locked    = (mcnt == LCK);

    always_ff @(posedge fastclk) begin
        if (reset) begin
            clk_sync  <= '0;
            trig_sync <= '0;
            clk_d     <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], clk_in};
            trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig_in};
            clk_d     <= clk_s;
            trig_d    <= trig_sync[SYNC_STAGES-1];
        end
    end

    // Loading 1 after an edge makes phase equal the cycles elapsed since that edge,
    // so at the next edge it is already the full period.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            phase <= '0;
            high  <= '0;
        end else begin
            phase <= clk_rise ? ONE : (phase == ONES ? phase : phase + ONE);
            high  <= clk_rise ? ONE : (clk_s && high != ONES ? high + ONE : high);
        end
    end

    always_comb begin
        hit = near(phase, P0) | near(phase, P1) | near(phase, P2) | near(phase, P3);
        dec = near(phase, P0) ? 2'd0 : near(phase, P1) ? 2'd1 : near(phase, P2) ? 2'd2 : 2'd3;
    end

    always_ff @(posedge fastclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (clk_rise ? MEAS : IDLE) : (tout ? IDLE : MEAS);
    end

    // An edge on the timeout cycle wins: it is a measurement, not a loss.
    always_comb begin
        meas = (state == MEAS) && clk_rise;
        tout = (state == MEAS) && !clk_rise && (phase == TMO);
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            sel_code   <= 2'd0;
            sel_valid  <= 1'b0;
            mcnt       <= '0;
            clk_lost   <= 1'b0;
            trig_pulse <= 1'b0;
            trig_count <= 8'd0;
            trig_phase <= '0;
        end else begin
            meas_valid <= meas;
            trig_pulse <= trig_rise;
            if (meas) begin
                period_out <= phase;
                high_out   <= high;
                clk_lost   <= 1'b0;
                sel_valid  <= hit;
                sel_code   <= hit ? dec : sel_code;
                mcnt       <= !hit ? '0 : (dec != sel_code ? M1 : (mcnt == LCK ? LCK : mcnt + M1));
            end
            if (tout) begin
                clk_lost  <= 1'b1;
                sel_valid <= 1'b0;
                mcnt      <= '0;
            end
            if (trig_rise) begin
                trig_count <= trig_count + 8'd1;
                trig_phase <= (state == IDLE || clk_rise) ? '0 : phase;
            end
        end
    end

`ifdef DUTY_CHECK_EN
    logic [CNT_W+1:0] twice_high, per_x, duty_diff;

    always_comb begin
        twice_high = {1'b0, high, 1'b0};
        per_x      = {2'b00, phase};
        duty_diff  = twice_high > per_x ? twice_high - per_x : per_x - twice_high;
    end

    always_ff @(posedge fastclk) begin
        if (reset)     duty_err <= 1'b0;
        else if (meas) duty_err <= duty_diff > (CNT_W+2)'(2 * TOL);
    end
`else
    assign duty_err = 1'b0;
`endif
endmodule

// File: tb/tb_clk_trig_monitor.sv
// tb_clk_trig_monitor: directed bench with an edge-timestamp model of clk_trig_monitor
module tb_clk_trig_monitor;
    localparam int TOL = 1, LOCK = 4, TMO = 1024, LAT = 3;
    localparam int PV[4] = '{4, 8, 16, 32};

    logic        fastclk = 1'b0, reset = 1'b1, clk_in = 1'b0, trig_in = 1'b0;
    logic [15:0] period_out, high_out, trig_phase;
    logic        meas_valid, sel_valid, locked, clk_lost, trig_pulse, duty_err;
    logic [1:0]  sel_code;
    logic [7:0]  trig_count;

    clk_trig_monitor dut (
        .fastclk(fastclk), .reset(reset), .clk_in(clk_in), .trig_in(trig_in),
        .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
        .sel_code(sel_code), .sel_valid(sel_valid), .locked(locked),
        .clk_lost(clk_lost), .trig_pulse(trig_pulse), .trig_count(trig_count),
        .trig_phase(trig_phase), .duty_err(duty_err)
    );

    always #5 fastclk = ~fastclk;

    typedef struct {
        logic        mv, sv, lk, lost, tp, de;
        logic [1:0]  sel;
        logic [7:0]  tc;
        logic [15:0] per, hi, tph;
    } exp_t;

    exp_t  cur, q[$];
    int    hist[$];
    int    checks = 0, errors = 0, ntp = 0;
    int    n = 0, last_rise = 0, hcnt = 0;
    bit    run = 0, started = 0;
    logic  prev_c = 1'b0, prev_t = 1'b0;

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Locked means the last LOCK results were all valid and all the same selection.
    function automatic bit model_locked();
        if (hist.size() < LOCK) return 0;
        for (int i = 1; i <= LOCK; i++)
            if (hist[hist.size()-i] < 0 || hist[hist.size()-i] != hist[hist.size()-1]) return 0;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // One input cycle of the model: outputs it predicts appear LAT cycles later.
    task automatic model_step(input logic c, input logic t);
        exp_t e;
        bit   rise, trise;
        int   per, code;
        e     = cur;
        e.mv  = 1'b0;
        e.tp  = 1'b0;
        rise  = c && !prev_c;
        trise = t && !prev_t;
        if (trise) begin
            e.tp  = 1'b1;
            e.tc  = cur.tc + 8'd1;
            e.tph = (!started || rise) ? 16'd0 : 16'(n - last_rise);
        end
        if (rise) begin
            if (started) begin
                per    = n - last_rise;
                e.mv   = 1'b1;
                e.per  = 16'(per);
                e.hi   = 16'(hcnt);
                e.lost = 1'b0;
                code   = -1;
                for (int x = 3; x >= 0; x--) if (iabs(per - PV[x]) <= TOL) code = x;
                e.sv = code >= 0;
                if (code >= 0) e.sel = 2'(code);
                hist.push_back(code);
                e.lk = model_locked();
`ifdef DUTY_CHECK_EN
                e.de = iabs(2 * hcnt - per) > 2 * TOL;
`endif
            end
            started   = 1;
            last_rise = n;
            hcnt      = 1;
        end else begin
            if (started && n - last_rise == TMO) begin
                e.lost  = 1'b1;
                e.sv    = 1'b0;
                e.lk    = 1'b0;
                started = 0;
                hist.push_back(-1);
            end
            hcnt += int'(c);
        end
        prev_c = c;
        prev_t = t;
        n++;
        cur = e;
        q.push_back(e);
    endtask

    task automatic cyc(input logic c, input logic t);
        @(posedge fastclk);
        #2;
        clk_in  = c;
        trig_in = t;
        model_step(c, t);
    endtask

    task automatic clk_run(input int per, input int hi, input int np, input int tof);
        for (int p = 0; p < np; p++)
            for (int i = 0; i < per; i++)
                cyc(i < hi, tof >= 0 && i >= tof && i < tof + 3);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0);
    endtask

    always @(negedge fastclk) begin : compare
        exp_t e;
        if (trig_pulse === 1'b1) ntp++;
        if (run && q.size() > LAT) begin
            e = q.pop_front();
            chk("meas_valid", meas_valid, e.mv);
            chk("period_out", period_out, e.per);
            chk("high_out", high_out, e.hi);
            chk("sel_code", sel_code, e.sel);
            chk("sel_valid", sel_valid, e.sv);
            chk("locked", locked, e.lk);
            chk("clk_lost", clk_lost, e.lost);
            chk("trig_pulse", trig_pulse, e.tp);
            chk("trig_count", trig_count, e.tc);
            chk("trig_phase", trig_phase, e.tph);
            chk("duty_err", duty_err, e.de);
        end
    end

    initial begin
        cur = '{default: '0};
        repeat (5) @(posedge fastclk);
        #2;
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_period", period_out, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lost", clk_lost, 0);
        chk("rst_trig_count", trig_count, 0);
        @(posedge fastclk);
        #2;
        reset = 1'b0;
        repeat (LAT) q.push_back(cur);
        run = 1;
        model_step(1'b0, 1'b0);
        idle(4);

        clk_run(8, 4, 6, -1);
        chk("p8_period", period_out, 8);
        chk("p8_high", high_out, 4);
        chk("p8_sel", sel_code, 1);
        chk("p8_valid", sel_valid, 1);
        chk("p8_locked", locked, 1);

        clk_run(16, 8, 6, -1);
        chk("p16_period", period_out, 16);
        chk("p16_sel", sel_code, 2);
        chk("p16_locked", locked, 1);

        idle(1100);
        chk("lost_set", clk_lost, 1);
        chk("lost_locked", locked, 0);
        chk("lost_valid", sel_valid, 0);

        clk_run(4, 2, 1, -1);
        chk("first_edge_no_meas", clk_lost, 1);
        clk_run(4, 2, 5, -1);
        chk("p4_lost_clear", clk_lost, 0);
        chk("p4_period", period_out, 4);
        chk("p4_sel", sel_code, 0);

        clk_run(12, 6, 3, -1);
        chk("p12_period", period_out, 12);
        chk("p12_valid", sel_valid, 0);
        chk("p12_locked", locked, 0);

        clk_run(1024, 512, 2, -1);
        chk("p1024_no_lost", clk_lost, 0);
        chk("p1024_period", period_out, 1024);

        ntp = 0;
        clk_run(32, 16, 256, 5);
        chk("trig_pulses", ntp, 256);
        chk("trig_wrap", trig_count, 0);
        chk("trig_phase5", trig_phase, 5);
        chk("p32_sel", sel_code, 3);
        chk("p32_locked", locked, 1);

        clk_run(16, 12, 3, -1);
`ifdef DUTY_CHECK_EN
        chk("duty_12of16", duty_err, 1);
`else
        chk("duty_12of16", duty_err, 0);
`endif
        chk("p16h12_high", high_out, 12);
        clk_run(16, 8, 3, 0);
        chk("duty_8of16", duty_err, 0);
        chk("trig_on_edge_phase", trig_phase, 0);

        idle(1100);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        idle(4);
        chk("idle_trig_count", trig_count, 4);
        chk("idle_trig_phase", trig_phase, 0);
        idle(LAT + 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
